// File: rtl/hi_lo_registers.sv
// HI/LO special-purpose register pair for multiply/divide results, read combinationally.
// Optional same-cycle write forwarding is enabled by defining HILO_BYPASS_EN.

module hi_lo_lane #(
  parameter int W = 32
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  input  logic         we_i,
  input  logic [W-1:0] wd_i,
  output logic [W-1:0] rd_o
);
  logic [W-1:0] data_q, data_d;

  always_comb begin
    data_d = data_q;
    if (we_i) data_d = wd_i;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) data_q <= '0;
    else          data_q <= data_d;
  end

`ifdef HILO_BYPASS_EN
  // Forward a pending write; reset wins so X enables during reset cannot leak out.
  always_comb begin
    rd_o = data_q;
    if (!rst_n_i)  rd_o = '0;
    else if (we_i) rd_o = wd_i;
  end
`else
  assign rd_o = data_q;
`endif
endmodule

module hi_lo_registers #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  HiWriteEnable,
  input  logic                  LoWriteEnable,
  input  logic [DATA_WIDTH-1:0] HiWriteData,
  input  logic [DATA_WIDTH-1:0] LoWriteData,
  output logic [DATA_WIDTH-1:0] HiReadData,
  output logic [DATA_WIDTH-1:0] LoReadData
);
  localparam int NUM_LANES = 2;

  // Lane 1 is HI, lane 0 is LO.
  logic [NUM_LANES-1:0]                 we;
  logic [NUM_LANES-1:0][DATA_WIDTH-1:0] wd;
  logic [NUM_LANES-1:0][DATA_WIDTH-1:0] rd;

  assign we         = {HiWriteEnable, LoWriteEnable};
  assign wd         = {HiWriteData, LoWriteData};
  assign HiReadData = rd[1];
  assign LoReadData = rd[0];

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    hi_lo_lane #(.W(DATA_WIDTH)) u_lane (
      .clk_i   (Clk),
      .rst_n_i (Reset),
      .we_i    (we[g]),
      .wd_i    (wd[g]),
      .rd_o    (rd[g])
    );
  end
endmodule

// File: tb/tb_hi_lo_registers.sv
// Randomised and directed checks of hi_lo_registers against a simple value model.
module tb_hi_lo_registers;
  logic        Clk = 1'b0;
  logic        Reset;
  logic        HiWriteEnable, LoWriteEnable;
  logic [31:0] HiWriteData, LoWriteData;
  logic [31:0] HiReadData, LoReadData;

  int checks = 0;
  int failures = 0;
  bit cmp_en = 1'b0;
  logic [31:0] hi_m = '0, lo_m = '0;

  always #5 Clk = ~Clk;

  hi_lo_registers #(.DATA_WIDTH(32)) dut (
    .Clk(Clk), .Reset(Reset),
    .HiWriteEnable(HiWriteEnable), .LoWriteEnable(LoWriteEnable),
    .HiWriteData(HiWriteData), .LoWriteData(LoWriteData),
    .HiReadData(HiReadData), .LoReadData(LoReadData)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h @%0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] exp_rd(input logic we, input logic [31:0] wd, input logic [31:0] stored);
`ifdef HILO_BYPASS_EN
    if (Reset !== 1'b1) return '0;
    return we ? wd : stored;
`else
    return stored;
`endif
  endfunction

  always @(negedge Clk) begin
    if (cmp_en) begin
      chk("hi_model", HiReadData, exp_rd(HiWriteEnable, HiWriteData, hi_m));
      chk("lo_model", LoReadData, exp_rd(LoWriteEnable, LoWriteData, lo_m));
    end
  end

  // Clock the current inputs into the model, then present the next inputs.
  task automatic apply(input logic he, input logic [31:0] hd,
                       input logic le, input logic [31:0] ld, input logic rst);
    @(posedge Clk);
    if (Reset === 1'b1) begin
      if (HiWriteEnable) hi_m = HiWriteData;
      if (LoWriteEnable) lo_m = LoWriteData;
    end
    #1;
    HiWriteEnable = he; HiWriteData = hd;
    LoWriteEnable = le; LoWriteData = ld;
    Reset = rst;
    if (!rst) begin hi_m = '0; lo_m = '0; end
  endtask

  initial begin
    Reset = 1'b0;
    HiWriteEnable = 1'b0; LoWriteEnable = 1'b0;
    HiWriteData = '0; LoWriteData = '0;
    #2;
    chk("reset_hi", HiReadData, 32'h0);
    chk("reset_lo", LoReadData, 32'h0);
    apply(0, 0, 0, 0, 1);
    cmp_en = 1'b1;

    // Preload, then assert reset mid-cycle with no clock edge.
    apply(1, 32'h1234, 1, 32'h5678, 1);
    apply(0, 0, 0, 0, 1);
    chk("preload_hi", HiReadData, 32'h1234);
    chk("preload_lo", LoReadData, 32'h5678);
    #1; Reset = 1'b0; hi_m = '0; lo_m = '0;
    #1;
    chk("async_rst_hi", HiReadData, 32'h0);
    chk("async_rst_lo", LoReadData, 32'h0);
    apply(0, 0, 0, 0, 1);
    chk("rst_release_hi", HiReadData, 32'h0);

    apply(1, 32'h00007F00, 0, 0, 1);
    apply(0, 0, 0, 0, 1);
    chk("hi_only_hi", HiReadData, 32'h00007F00);
    chk("hi_only_lo", LoReadData, 32'h0);

    apply(0, 0, 1, 32'h000000FF, 1);
    apply(0, 0, 0, 0, 1);
    chk("lo_only_lo", LoReadData, 32'h000000FF);
    chk("lo_only_hi", HiReadData, 32'h00007F00);

    apply(1, 32'h0000700F, 1, 32'h00000FF0, 1);
    apply(0, 32'hAAAA5555, 0, 32'h5555AAAA, 1);
    chk("both_hi", HiReadData, 32'h0000700F);
    chk("both_lo", LoReadData, 32'h00000FF0);
    apply(0, 32'h12345678, 0, 32'h87654321, 1);
    chk("no_en_hi", HiReadData, 32'h0000700F);
    chk("no_en_lo", LoReadData, 32'h00000FF0);

    // Pending HI write: forwarded only in the bypass build.
    apply(1, 32'hDEADBEEF, 0, 0, 1);
    #1;
`ifdef HILO_BYPASS_EN
    chk("bypass_pre_edge", HiReadData, 32'hDEADBEEF);
`else
    chk("no_bypass_pre_edge", HiReadData, 32'h0000700F);
`endif
    apply(0, 0, 0, 0, 1);
    chk("bypass_post_edge", HiReadData, 32'hDEADBEEF);

    // Write edge while reset is low is discarded.
    apply(1, 32'hFFFFFFFF, 1, 32'hFFFFFFFF, 0);
    apply(1, 32'hFFFFFFFF, 1, 32'hFFFFFFFF, 0);
    #1;
    chk("rst_vs_wr_hi", HiReadData, 32'h0);
    chk("rst_vs_wr_lo", LoReadData, 32'h0);
    apply(0, 0, 0, 0, 1);
    chk("rst_vs_wr_rel", HiReadData, 32'h0);

    for (int i = 0; i < 400; i++)
      apply(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)), $urandom,
            1'($urandom_range(0, 19) != 0));
    apply(0, 0, 0, 0, 1);
    @(negedge Clk);
    cmp_en = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
